// File: rtl/stopwatch_pkg.sv
// Shared types and digit-layout helpers for the BCD stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused,
        StExpired
    } sw_state_e;

    typedef logic [3:0] bcd_t;

    localparam int unsigned HundMax     = 9;
    localparam int unsigned SecUnitsMax = 9;
    localparam int unsigned SecTensMax  = 5;
    localparam int unsigned MinMax      = 9;

    function automatic int unsigned time_width(input int unsigned min_digits);
        return 16 + 4 * min_digits;
    endfunction

    // Digit 0 is hundredths units; digit 3 is the seconds tens digit.
    function automatic int unsigned digit_max(input int unsigned idx);
        if (idx < 2)       return HundMax;
        else if (idx == 2) return SecUnitsMax;
        else if (idx == 3) return SecTensMax;
        else               return MinMax;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counting modulo MAX+1 in either direction, with clamped load.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic load_i,
    input  bcd_t load_val_i,
    input  logic inc_i,
    input  logic dec_i,
    output bcd_t value_o,
    output logic carry_o
);

    localparam bcd_t Max = bcd_t'(MAX);

    bcd_t value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clear_i) begin
            value_d = '0;
        end else if (load_i) begin
            value_d = (load_val_i > Max) ? Max : load_val_i;
        end else if (inc_i) begin
            value_d = (value_q == Max) ? '0 : value_q + 4'd1;
        end else if (dec_i) begin
            value_d = (value_q == '0) ? Max : value_q - 4'd1;
        end
    end

    // Carry on up-rollover, borrow on down-rollover; the chain's direction is set upstream.
    assign carry_o = (inc_i && (value_q == Max)) || (dec_i && (value_q == '0));
    assign value_o = value_q;

    always_ff @(posedge clk) begin
        if (reset) value_q <= '0;
        else       value_q <= value_d;
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS:HH BCD stopwatch / countdown timer with prescaler and state machine.
// Optional lap capture register enabled by defining LAP_EN.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TICK_HZ    = 100,
    parameter int unsigned MIN_DIGITS = 2,
    localparam int unsigned TW        = time_width(MIN_DIGITS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          pause,
    input  logic          clear,
    input  logic          mode_down,
    input  logic          load_valid,
    input  logic [TW-1:0] load_value,
    output logic [TW-1:0] time_bcd,
    output logic          running,
    output logic          expired,
    output logic          wrapped
`ifdef LAP_EN
    ,
    input  logic          lap,
    output logic [TW-1:0] lap_bcd
`endif
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW       = $clog2(TICK_DIV);
    localparam int unsigned ND       = 4 + MIN_DIGITS;

    sw_state_e       state_q, state_d;
    logic            mode_q, mode_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            wrapped_q, wrapped_d;
    logic            expired_q, expired_d;
    logic            tick, clr_time, load_time;
    logic [ND:0]     chain;
    logic [TW-1:0]   cur_time;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        presc_d   = presc_q;
        clr_time  = 1'b0;
        load_time = 1'b0;
        tick      = 1'b0;
        expired_d = 1'b0;
        if (clear) begin
            state_d  = StIdle;
            presc_d  = '0;
            clr_time = 1'b1;
        end else if (load_valid && (state_q != StRun)) begin
            state_d   = StIdle;
            presc_d   = '0;
            load_time = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A countdown from zero would expire immediately, so it is refused.
                    if (start && !pause && !(mode_down && (cur_time == '0))) begin
                        state_d = StRun;
                        mode_d  = mode_down;
                        presc_d = '0;
                    end
                end
                StRun: begin
                    if (pause) begin
                        state_d = StPaused;
                    end else if (presc_q == PW'(TICK_DIV - 1)) begin
                        presc_d = '0;
                        tick    = 1'b1;
                        if (mode_q && (cur_time == TW'(1))) begin
                            state_d   = StExpired;
                            expired_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                StPaused: begin
                    if (start && !pause) state_d = StRun;
                end
                StExpired: ;
                default: state_d = StIdle;
            endcase
        end
    end

    assign chain[0]  = tick;
    // Only an up-count can carry out of the top digit; a countdown stops at zero first.
    assign wrapped_d = chain[ND] & ~mode_q;

    for (genvar i = 0; i < ND; i++) begin : g_digit
        bcd_digit #(
            .MAX(digit_max(i))
        ) u_digit (
            .clk       (clk),
            .reset     (reset),
            .clear_i   (clr_time),
            .load_i    (load_time),
            .load_val_i(load_value[4*i +: 4]),
            .inc_i     (chain[i] & ~mode_q),
            .dec_i     (chain[i] & mode_q),
            .value_o   (cur_time[4*i +: 4]),
            .carry_o   (chain[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            mode_q    <= 1'b0;
            presc_q   <= '0;
            wrapped_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            presc_q   <= presc_d;
            wrapped_q <= wrapped_d;
            expired_q <= expired_d;
        end
    end

    assign time_bcd = cur_time;
    assign running  = (state_q == StRun);
    assign expired  = expired_q;
    assign wrapped  = wrapped_q;

`ifdef LAP_EN
    logic [TW-1:0] lap_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lap_q <= '0;
        end else if (lap && ((state_q == StRun) || (state_q == StPaused))) begin
            lap_q <= cur_time;
        end
    end

    assign lap_bcd = lap_q;
`endif

endmodule
